// File: rtl/spi_master.sv
// SPI master: shifts one n-bit word out on mosi (MSB first) while shifting one in from miso.
// Define SPI_MASTER_CS_EN to add the cs_n port and the LEAD/TRAIL chip-select guard phases.
module spi_master #(
    parameter int n       = 8,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         start,
    input  logic [n-1:0] tx_data,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] rx_data,
    output logic         spi_clk,
    output logic         mosi,
    input  logic         miso
`ifdef SPI_MASTER_CS_EN
    ,
    output logic         cs_n
`endif
);

    localparam int HW = $clog2(CLK_DIV);
    localparam int BW = $clog2(n);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(n - 1);

`ifdef SPI_MASTER_CS_EN
    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
`endif

    state_t         state_reg, state_next;
    logic [HW-1:0]  half_reg, half_next;
    logic [BW-1:0]  bit_reg, bit_next;
    // The MSB goes straight to mosi at load time, so only the remaining n-1 bits are kept.
    logic [n-2:0]   tx_reg, tx_next;
    logic [n-1:0]   rx_reg, rx_next;
    logic [n-1:0]   rx_data_reg, rx_data_next;
    logic           spi_clk_reg, spi_clk_next;
    logic           mosi_reg, mosi_next;
`ifdef SPI_MASTER_CS_EN
    logic           cs_n_reg, cs_n_next;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg   <= IDLE;
            half_reg    <= '0;
            bit_reg     <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            rx_data_reg <= '0;
            spi_clk_reg <= 1'b0;
            mosi_reg    <= 1'b0;
`ifdef SPI_MASTER_CS_EN
            cs_n_reg    <= 1'b1;
`endif
        end else begin
            state_reg   <= state_next;
            half_reg    <= half_next;
            bit_reg     <= bit_next;
            tx_reg      <= tx_next;
            rx_reg      <= rx_next;
            rx_data_reg <= rx_data_next;
            spi_clk_reg <= spi_clk_next;
            mosi_reg    <= mosi_next;
`ifdef SPI_MASTER_CS_EN
            cs_n_reg    <= cs_n_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        half_next    = half_reg;
        bit_next     = bit_reg;
        tx_next      = tx_reg;
        rx_next      = rx_reg;
        rx_data_next = rx_data_reg;
        spi_clk_next = spi_clk_reg;
        mosi_next    = mosi_reg;
`ifdef SPI_MASTER_CS_EN
        cs_n_next    = cs_n_reg;
`endif
        case (state_reg)
            // DONE accepts start exactly like IDLE so transfers can run back-to-back.
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    tx_next   = tx_data[n-2:0];
                    mosi_next = tx_data[n-1];
                    half_next = '0;
                    bit_next  = '0;
`ifdef SPI_MASTER_CS_EN
                    cs_n_next  = 1'b0;
                    state_next = LEAD;
`else
                    spi_clk_next = 1'b1;
                    state_next   = HIGH;
`endif
                end
            end
`ifdef SPI_MASTER_CS_EN
            LEAD: begin
                if (half_reg == HALF_LAST) begin
                    half_next    = '0;
                    spi_clk_next = 1'b1;
                    state_next   = HIGH;
                end else begin
                    half_next = half_reg + HW'(1);
                end
            end
`endif
            HIGH: begin
                if (half_reg == HALF_LAST) begin
                    half_next    = '0;
                    spi_clk_next = 1'b0;
                    rx_next      = {rx_reg[n-2:0], miso};
                    state_next   = LOW;
                end else begin
                    half_next = half_reg + HW'(1);
                end
            end
            LOW: begin
                if (half_reg == HALF_LAST) begin
                    half_next = '0;
                    if (bit_reg == BIT_LAST) begin
`ifdef SPI_MASTER_CS_EN
                        state_next = TRAIL;
`else
                        rx_data_next = rx_reg;
                        state_next   = DONE;
`endif
                    end else begin
                        bit_next     = bit_reg + BW'(1);
                        spi_clk_next = 1'b1;
                        mosi_next    = tx_reg[n-2];
                        tx_next      = tx_reg << 1;
                        state_next   = HIGH;
                    end
                end else begin
                    half_next = half_reg + HW'(1);
                end
            end
`ifdef SPI_MASTER_CS_EN
            TRAIL: begin
                if (half_reg == HALF_LAST) begin
                    half_next    = '0;
                    rx_data_next = rx_reg;
                    cs_n_next    = 1'b1;
                    state_next   = DONE;
                end else begin
                    half_next = half_reg + HW'(1);
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state_reg != IDLE) && (state_reg != DONE);
    assign done    = (state_reg == DONE);
    assign rx_data = rx_data_reg;
    assign spi_clk = spi_clk_reg;
    assign mosi    = mosi_reg;
`ifdef SPI_MASTER_CS_EN
    assign cs_n    = cs_n_reg;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: edge-detecting slave shift register plus a
// per-cycle reference model that derives every output from the transfer start cycle.
module tb_spi_master;

    localparam int N  = 8;
    localparam int CD = 4;
`ifdef SPI_MASTER_CS_EN
    localparam int LEADC   = CD;
    localparam int LAT_LIT = 73;
`else
    localparam int LEADC   = 0;
    localparam int LAT_LIT = 65;
`endif
    localparam int LAT = 1 + 2 * LEADC + 2 * N * CD;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         nreset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] tx_data = '0;
    logic         busy, done, spi_clk, mosi;
    logic [N-1:0] rx_data;
    logic         miso = 1'b0;
`ifdef SPI_MASTER_CS_EN
    logic         cs_n;
`endif

    spi_master #(.n(N), .CLK_DIV(CD)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .spi_clk (spi_clk),
        .mosi    (mosi),
        .miso    (miso)
`ifdef SPI_MASTER_CS_EN
        ,
        .cs_n    (cs_n)
`endif
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_count = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_count <= done_count + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Slave shift register: edge-detects spi_clk, drives miso after rising, samples mosi after falling.
    logic [N-1:0] slave_reg = '0;
    logic [N-1:0] load_val = '0;
    logic         load_req = 1'b0;
    logic         spi_prev = 1'b0;
    always @(posedge clk) begin
        spi_prev <= spi_clk;
        if (load_req) slave_reg <= load_val;
        else if (spi_prev && !spi_clk) slave_reg <= {slave_reg[N-2:0], mosi};
        if (!spi_prev && spi_clk) miso <= slave_reg[N-1];
    end

    // Reference model: outputs follow from cycles elapsed since the accepted start.
    bit           m_active = 0;
    int           m_t0 = 0;
    logic [N-1:0] m_tx = '0, m_rx_exp = '0, m_last_rx = '0;
    logic         m_last_mosi = 1'b0;
    logic         e_busy, e_done, e_spi, e_mosi, e_cs;
    logic [N-1:0] e_rx;
    int           m_d, m_ph, m_k;
    bit           m_idle_ok;

    always @(negedge clk) begin
        if (!nreset) begin
            m_active = 0; m_last_mosi = 1'b0; m_last_rx = '0;
            e_busy = 0; e_done = 0; e_spi = 0; e_mosi = 0; e_cs = 1; e_rx = '0;
        end else begin
            e_busy = 0; e_done = 0; e_spi = 0; e_cs = 1;
            e_mosi = m_last_mosi; e_rx = m_last_rx; m_idle_ok = !m_active;
            if (m_active) begin
                m_d = cyc - m_t0;
                if (m_d >= LAT) begin
                    e_done = 1; e_rx = m_rx_exp; e_mosi = m_tx[0];
                    m_last_rx = m_rx_exp; m_last_mosi = m_tx[0];
                    m_active = 0; m_idle_ok = 1;
                    check("slave_word", slave_reg, m_tx);
                end else begin
                    e_busy = 1; e_cs = 0;
                    m_ph = m_d - 1 - LEADC;
                    if (m_ph < 0) e_mosi = m_tx[N-1];
                    else if (m_ph >= 2 * N * CD) e_mosi = m_tx[0];
                    else begin
                        m_k = m_ph / (2 * CD);
                        e_spi = ((m_ph / CD) % 2) == 0;
                        e_mosi = m_tx[N-1-m_k];
                    end
                end
            end
        end
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("spi_clk", spi_clk, e_spi);
        check("mosi", mosi, e_mosi);
        check("rx_data", rx_data, e_rx);
`ifdef SPI_MASTER_CS_EN
        check("cs_n", cs_n, e_cs);
`endif
        if (nreset && start && m_idle_ok) begin
            m_active = 1; m_t0 = cyc; m_tx = tx_data; m_rx_exp = slave_reg;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [N-1:0] v);
        load_val = v; load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic wait_done(output int when);
        bit got = 0;
        when = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (done) begin got = 1; when = cyc; end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL done_timeout at cycle %0d: got no done expected done within 300 cycles", cyc);
        end
    endtask

    task automatic xfer(input logic [N-1:0] tx, input logic [N-1:0] slv, input bit noise,
                        output int lat, output logic [N-1:0] rx);
        int t; bit got = 0;
        preload(slv);
        start = 1'b1; tx_data = tx; t = cyc;
        tick();
        start = 1'b0; tx_data = N'($urandom);
        lat = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (done) begin
                got = 1; lat = cyc - t;
            end else begin
                start = noise && ($urandom_range(0, 3) == 0);
                if (start) tx_data = N'($urandom);
            end
        end
        start = 1'b0;
        rx = rx_data;
        if (!got) begin
            checks++; failures++;
            $display("FAIL xfer_timeout at cycle %0d: got no done expected done within 300 cycles", cyc);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog at time %0t: got no finish expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, t, dc0, w;
        logic [N-1:0] rx, slv, tx;

        #1 nreset = 1'b0;
        #2;
        check("rst_spi_clk", spi_clk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx_data", rx_data, 0);
`ifdef SPI_MASTER_CS_EN
        check("rst_cs_n", cs_n, 1);
`endif
        clk_en = 1'b1;
        tick(); tick();
        nreset = 1'b1;
        tick();

        // Basic full-duplex transfer.
        xfer(8'hA5, 8'h3C, 0, lat, rx);
        check("basic_latency", lat, LAT_LIT);
        check("basic_rx", rx, 8'h3C);
        check("basic_slave", slave_reg, 8'hA5);
        $display("xfer basic tx=0xa5 rx=0x%0h lat=%0d", rx, lat);

        // Busy guard: a second start during bit 3 must be ignored.
        preload(8'h00);
        dc0 = done_count;
        start = 1'b1; tx_data = 8'h81;
        tick();
        start = 1'b0;
        repeat (LEADC + 3 * 2 * CD + 1) tick();
        start = 1'b1; tx_data = 8'hFF;
        tick();
        start = 1'b0;
        wait_done(w);
        tick(); tick();
        check("guard_done_count", done_count - dc0, 1);
        check("guard_slave", slave_reg, 8'h81);
        $display("xfer busy_guard tx=0x81 slave=0x%0h dones=%0d", slave_reg, done_count - dc0);

        // Back-to-back with start held high.
        preload(8'h77);
        start = 1'b1; tx_data = 8'h12;
        tick();
        tx_data = 8'h34;
        wait_done(w);
        check("b2b_rx_first", rx_data, 8'h77);
        check("b2b_slave_first", slave_reg, 8'h12);
        tick();
        start = 1'b0;
        check("b2b_busy_next", busy, 1);
        wait_done(t);
        check("b2b_gap", t - w, LAT_LIT);
        check("b2b_rx_second", rx_data, 8'h12);
        check("b2b_slave_second", slave_reg, 8'h34);
        $display("xfer back_to_back rx2=0x%0h slave=0x%0h", rx_data, slave_reg);

        // Reset during bit 4 aborts without done.
        preload(8'h96);
        dc0 = done_count;
        start = 1'b1; tx_data = 8'h33;
        tick();
        start = 1'b0;
        repeat (LEADC + 4 * 2 * CD + 1) tick();
        nreset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_spi_clk", spi_clk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_rx_data", rx_data, 0);
        tick(); tick();
        nreset = 1'b1;
        tick(); tick();
        check("abort_no_done", done_count - dc0, 0);
        xfer(8'h5A, 8'hE1, 0, lat, rx);
        check("after_abort_rx", rx, 8'hE1);
        check("after_abort_slave", slave_reg, 8'h5A);
        $display("xfer after_abort tx=0x5a rx=0x%0h", rx);

        // Randomized transfers with stray start pulses while busy.
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            tx = N'($urandom); slv = N'($urandom);
            xfer(tx, slv, 1, lat, rx);
            check("rand_latency", lat, LAT_LIT);
            check("rand_rx", rx, slv);
            $display("xfer rand%0d tx=0x%0h slv=0x%0h rx=0x%0h lat=%0d", i, tx, slv, rx, lat);
        end

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
